// File: rtl/serial_paralelo_rx.sv
// serial_paralelo_rx: receives an SD CMD-line response frame (n bits, MSB first)
// after a start bit, with a bounded wait (NCR) for that start bit.
// Optional CRC7 check over bits n-1..8 against bits 7..1 is built when the
// macro SERIAL_PARALELO_RX_CRC7_EN is defined; otherwise crc_error is tied low.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | disarmed; waits for a rising edge of enable
// WAIT_START | armed; watches for serial=0, down-counts the NCR window
// RECEIVE    | start bit seen; samples one bit per clock into its position
// DONE       | frame captured or timed out; outputs hold until enable=0
module serial_paralelo_rx #(
  parameter int n              = 48,
  parameter int timeout_cycles = 64
) (
  input  logic         sd_clock,
  input  logic         reset,
  input  logic         enable,
  input  logic         serial,
  output logic [n-1:0] parallel,
  output logic         complete,
  output logic         timeout,
  output logic         frame_error,
  output logic         crc_error
);

  localparam int cw = $clog2(n);
  localparam int tw = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_START, RECEIVE, DONE} state_t;

  state_t         state, state_nx;
  logic           enable_q;
  logic [tw-1:0]  wait_cnt;
  logic [cw-1:0]  count;
  logic [cw-1:0]  bit_idx;
  logic [n-1:0]   shift;
  logic           capture;
  logic           arm, start_hit, rx_bit, load;

  // Bits land directly in their final position; the start bit sits at n-1.
  assign bit_idx   = cw'(n-1) - count;
  assign arm       = (state == IDLE) && (state_nx == WAIT_START);
  assign start_hit = (state == WAIT_START) && enable && !serial;
  assign rx_bit    = (state == RECEIVE) && enable;
  assign load      = (state == DONE) && enable && capture;

  // Next-state decode; enable low always wins and returns to IDLE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:       if (enable && !enable_q) state_nx = WAIT_START;
      WAIT_START: if (!enable)             state_nx = IDLE;
                  else if (!serial)        state_nx = RECEIVE;
                  else if (wait_cnt == '0) state_nx = DONE;
      RECEIVE:    if (!enable)             state_nx = IDLE;
                  else if (count == cw'(n-1)) state_nx = DONE;
      DONE:       if (!enable)             state_nx = IDLE;
      default:    state_nx = IDLE;
    endcase
  end

  // State register, counters, shift register and result flags.
  // enable_q resets high so an enable held through reset must drop and rise again.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      enable_q    <= 1'b1;
      wait_cnt    <= '0;
      count       <= '0;
      shift       <= '0;
      capture     <= 1'b0;
      parallel    <= '0;
      complete    <= 1'b0;
      timeout     <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state    <= state_nx;
      enable_q <= enable;
      capture  <= 1'b0;
      if (arm) begin
        wait_cnt    <= tw'(timeout_cycles - 1);
        count       <= '0;
        complete    <= 1'b0;
        timeout     <= 1'b0;
        frame_error <= 1'b0;
      end
      if (state == WAIT_START && enable) begin
        if (!serial) begin
          shift <= '0;
          count <= cw'(1);
        end else if (wait_cnt == '0) begin
          timeout  <= 1'b1;
          complete <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt - 1'b1;
        end
      end
      if (rx_bit) begin
        shift[bit_idx] <= serial;
        if (count == cw'(n-1)) capture <= 1'b1;
        else                   count   <= count + 1'b1;
      end
      // Capture happens one clock after the last bit, giving n-cycle latency.
      if (state == DONE) begin
        if (!enable) begin
          complete <= 1'b0;
        end else if (capture) begin
          parallel    <= shift;
          complete    <= 1'b1;
          frame_error <= shift[n-1] | shift[n-2] | ~shift[0];
        end
      end
    end
  end

`ifdef SERIAL_PARALELO_RX_CRC7_EN
  logic [6:0] crc;
  logic       crc_fb;

  assign crc_fb = crc[6] ^ serial;

  // Serial CRC7 (x^7+x^3+1, init 0); the start bit is 0 so it leaves crc at 0.
  always_ff @(posedge sd_clock or posedge reset) begin
    if (reset) begin
      crc       <= '0;
      crc_error <= 1'b0;
    end else begin
      if (arm) crc_error <= 1'b0;
      if (start_hit) begin
        crc <= '0;
      end else if (rx_bit && count <= cw'(n-9)) begin
        crc <= {crc[5:0], 1'b0} ^ (crc_fb ? 7'h09 : 7'h00);
      end
      if (load) crc_error <= (crc != shift[7:1]);
    end
  end
`else
  assign crc_error = 1'b0;
`endif

endmodule

// File: tb/tb_serial_paralelo_rx.sv
// Bench for serial_paralelo_rx: table frames, random frames, timeout,
// abort, mid-frame reset and reset-with-enable-held sequences.
module tb_serial_paralelo_rx;
  localparam int N  = 48;
  localparam int TO = 64;

  logic          sd_clock = 1'b0;
  logic          reset, enable, serial;
  logic [N-1:0]  parallel;
  logic          complete, timeout, frame_error, crc_error;

  int checks = 0;
  int errors = 0;
  logic [N-1:0] ref_par;

  serial_paralelo_rx #(.n(N), .timeout_cycles(TO)) dut (
    .sd_clock(sd_clock), .reset(reset), .enable(enable), .serial(serial),
    .parallel(parallel), .complete(complete), .timeout(timeout),
    .frame_error(frame_error), .crc_error(crc_error)
  );

  always #5 sd_clock = ~sd_clock;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7_ref(input logic [N-1:0] f);
    logic [46:0] r;
    r = {f[47:8], 7'b0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    return r[6:0];
  endfunction

  function automatic logic exp_crc_err(input logic [N-1:0] f);
`ifdef SERIAL_PARALELO_RX_CRC7_EN
    return crc7_ref(f) != f[7:1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic send_frame(input logic [N-1:0] f, input int idle, input logic exp_ferr);
    @(negedge sd_clock); enable = 1'b1; serial = 1'b1;
    @(posedge sd_clock); #1;
    check("arm_complete", complete, 0);
    check("arm_timeout", timeout, 0);
    check("arm_frame_error", frame_error, 0);
    repeat (idle) @(posedge sd_clock);
    for (int i = N-1; i >= 0; i--) begin
      @(negedge sd_clock); serial = f[i];
      @(posedge sd_clock);
    end
    #1 check("complete_early", complete, 0);
    @(negedge sd_clock); serial = 1'($urandom);
    @(posedge sd_clock); #1;
    check("complete", complete, 1);
    check("parallel", parallel, f);
    check("frame_error", frame_error, exp_ferr);
    check("crc_error", crc_error, exp_crc_err(f));
    check("timeout_clear", timeout, 0);
    ref_par = f;
    repeat (4) begin
      @(negedge sd_clock); serial = 1'($urandom);
    end
    #1;
    check("done_hold_complete", complete, 1);
    check("done_hold_parallel", parallel, ref_par);
    @(negedge sd_clock); enable = 1'b0; serial = 1'b1;
    @(posedge sd_clock); #1;
    check("release_complete", complete, 0);
    check("release_parallel", parallel, ref_par);
    check("release_frame_error", frame_error, exp_ferr);
  endtask

  typedef struct {
    logic [N-1:0] frame;
    logic         ferr;
    int           idle;
  } vec_t;

  vec_t vecs[5];

  initial begin
    logic [N-1:0] f;
    logic         ferr;

    vecs[0] = '{48'h08000001AA13, 1'b0, 5};
    vecs[1] = '{48'h08000001AA12, 1'b1, 5};
    vecs[2] = '{48'h08000001AA13 ^ 48'h000000100000, 1'b0, 0};
    vecs[3] = '{48'h48000001AA13, 1'b1, 3};
    vecs[4] = '{48'h3FFFFFFFFFFF, 1'b0, 63};

    reset = 1'b1; enable = 1'b0; serial = 1'b1; ref_par = '0;
    repeat (3) @(posedge sd_clock);
    #1;
    check("rst_parallel", parallel, 0);
    check("rst_complete", complete, 0);
    check("rst_timeout", timeout, 0);
    check("rst_frame_error", frame_error, 0);
    check("rst_crc_error", crc_error, 0);

    // enable held through reset release must not arm the receiver
    @(negedge sd_clock); enable = 1'b1; serial = 1'b0;
    @(negedge sd_clock); reset = 1'b0;
    repeat (70) @(posedge sd_clock);
    #1;
    check("no_arm_complete", complete, 0);
    check("no_arm_timeout", timeout, 0);
    check("no_arm_parallel", parallel, ref_par);
    @(negedge sd_clock); enable = 1'b0; serial = 1'b1;
    @(posedge sd_clock);

    for (int v = 0; v < 5; v++)
      send_frame(vecs[v].frame, vecs[v].idle, vecs[v].ferr);

    for (int k = 0; k < 8; k++) begin
      f = {16'($urandom), 32'($urandom)};
      f[47] = 1'b0;
      if ($urandom_range(1, 0) == 1) begin
        f[46] = 1'b0;
        f[0]  = 1'b1;
        f[7:1] = crc7_ref(f);
      end
      ferr = f[46] | ~f[0];
      send_frame(f, int'($urandom_range(20, 0)), ferr);
    end

    // timeout: 64 high samples after arming
    @(negedge sd_clock); enable = 1'b1; serial = 1'b1;
    @(posedge sd_clock);
    repeat (TO-1) @(posedge sd_clock);
    #1;
    check("to_early_complete", complete, 0);
    check("to_early_timeout", timeout, 0);
    @(posedge sd_clock); #1;
    check("to_complete", complete, 1);
    check("to_timeout", timeout, 1);
    check("to_parallel", parallel, ref_par);
    @(negedge sd_clock); enable = 1'b0;
    @(posedge sd_clock); #1;
    check("to_release_complete", complete, 0);
    check("to_release_timeout", timeout, 1);

    // abort at bit 20
    f = 48'h08000001AA13;
    @(negedge sd_clock); enable = 1'b1; serial = 1'b1;
    @(posedge sd_clock);
    repeat (2) @(posedge sd_clock);
    for (int i = N-1; i > N-1-20; i--) begin
      @(negedge sd_clock); serial = f[i];
      @(posedge sd_clock);
    end
    @(negedge sd_clock); enable = 1'b0; serial = f[N-21];
    @(posedge sd_clock); #1;
    check("abort_complete", complete, 0);
    for (int i = N-22; i >= 0; i--) begin
      @(negedge sd_clock); serial = f[i];
    end
    repeat (10) @(posedge sd_clock);
    #1;
    check("abort_late_complete", complete, 0);
    check("abort_parallel", parallel, ref_par);
    send_frame(48'h08000001AA13, 4, 1'b0);

    // asynchronous reset at bit 30
    @(negedge sd_clock); enable = 1'b1; serial = 1'b1;
    @(posedge sd_clock);
    for (int i = N-1; i > N-1-30; i--) begin
      @(negedge sd_clock); serial = f[i];
      @(posedge sd_clock);
    end
    #2 reset = 1'b1;
    #1;
    check("midrst_parallel", parallel, 0);
    check("midrst_complete", complete, 0);
    check("midrst_timeout", timeout, 0);
    check("midrst_frame_error", frame_error, 0);
    check("midrst_crc_error", crc_error, 0);
    ref_par = '0;
    @(negedge sd_clock); reset = 1'b0;
    for (int i = N-31; i >= 0; i--) begin
      @(negedge sd_clock); serial = f[i];
    end
    @(negedge sd_clock); serial = 1'b0;
    repeat (70) @(posedge sd_clock);
    #1;
    check("midrst_after_complete", complete, 0);
    check("midrst_after_timeout", timeout, 0);
    @(negedge sd_clock); enable = 1'b0; serial = 1'b1;
    @(posedge sd_clock);
    send_frame(48'h08000001AA13, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
